// File: rtl/hv_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hv_ctrl_pkg                                                          |
// | Shared types for the HV encoder microcoded controller.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package hv_ctrl_pkg;

    localparam int CtrlWidth = 34;

    typedef enum logic [1:0] {
        EXEC = 2'b00,
        NOP  = 2'b01,
        WAIT = 2'b10,
        END  = 2'b11
    } inst_kind_e;

    // Field order follows the encoder control ports, MSB first.
    typedef struct packed {
        logic [1:0] alu_mux_a;
        logic [1:0] alu_mux_b;
        logic [1:0] alu_op;
        logic [6:0] alu_shift_amt;
        logic [1:0] bund_mux_a;
        logic [1:0] bund_mux_b;
        logic       bund_a_valid;
        logic       bund_b_valid;
        logic       bund_a_clr;
        logic       bund_b_clr;
        logic [1:0] reg_wr_mux;
        logic [1:0] reg_wr_addr;
        logic [1:0] reg_rd_addr_a;
        logic [1:0] reg_rd_addr_b;
        logic       reg_wr_en;
        logic       qhv_clr;
        logic       qhv_wr_en;
        logic [1:0] qhv_mux;
    } ctrl_word_t;

endpackage
`default_nettype wire

// File: rtl/hv_ctrl_imem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hv_ctrl_imem                                                         |
// | 1W/1R instruction store, asynchronous read, not cleared by reset.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hv_ctrl_imem #(
    parameter int NumInst   = 32,
    parameter int InstWidth = 36,
    parameter int AddrWidth = $clog2(NumInst)
) (
    input  logic                 clk_i,
    input  logic                 wr_en_i,
    input  logic [AddrWidth-1:0] wr_addr_i,
    input  logic [InstWidth-1:0] wr_data_i,
    input  logic [AddrWidth-1:0] rd_addr_i,
    output logic [InstWidth-1:0] rd_data_o
);

    logic [InstWidth-1:0] mem_q [NumInst];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/hv_encoder_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hv_encoder_ctrl                                                      |
// | Microcoded sequencer issuing one registered encoder control word/cyc.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hv_encoder_ctrl #(
    parameter int NumInst      = 32,
    parameter int CtrlWidth    = hv_ctrl_pkg::CtrlWidth,
    parameter int LoopCntWidth = 8,
    parameter int InstWidth    = CtrlWidth + 2,
    parameter int AddrWidth    = $clog2(NumInst)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    prog_wr_en_i,
    input  logic [AddrWidth-1:0]    prog_wr_addr_i,
    input  logic [InstWidth-1:0]    prog_wr_data_i,
    input  logic [AddrWidth-1:0]    loop_start_i,
    input  logic [AddrWidth-1:0]    loop_end_i,
    input  logic [LoopCntWidth-1:0] loop_count_i,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [CtrlWidth-1:0]    ctrl_o,
    output logic [AddrWidth-1:0]    pc_o
);
    import hv_ctrl_pkg::*;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumInst - 1);

    state_e                  state_q, state_d;
    logic [AddrWidth-1:0]    pc_q, pc_d;
    logic [LoopCntWidth-1:0] loop_cnt_q, loop_cnt_d;
    logic [AddrWidth-1:0]    loop_start_q, loop_start_d;
    logic [AddrWidth-1:0]    loop_end_q, loop_end_d;
    logic [CtrlWidth-1:0]    ctrl_q, ctrl_d;
    logic                    done_q, done_d;
    logic                    in_ready_d;

    logic [InstWidth-1:0]    inst;
    inst_kind_e              kind;
    logic [CtrlWidth-1:0]    payload;
    logic                    advance;

    hv_ctrl_imem #(
        .NumInst   (NumInst),
        .InstWidth (InstWidth),
        .AddrWidth (AddrWidth)
    ) u_imem (
        .clk_i     (clk_i),
        .wr_en_i   (prog_wr_en_i && (state_q == ST_IDLE)),
        .wr_addr_i (prog_wr_addr_i),
        .wr_data_i (prog_wr_data_i),
        .rd_addr_i (pc_q),
        .rd_data_o (inst)
    );

    assign kind    = inst_kind_e'(inst[InstWidth-1 -: 2]);
    assign payload = inst[CtrlWidth-1:0];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        loop_cnt_d   = loop_cnt_q;
        loop_start_d = loop_start_q;
        loop_end_d   = loop_end_q;
        ctrl_d       = '0;
        done_d       = 1'b0;
        in_ready_d   = 1'b0;
        advance      = 1'b0;

        if (state_q == ST_IDLE) begin
            if (start_i) begin
                state_d      = ST_RUN;
                pc_d         = '0;
                loop_cnt_d   = loop_count_i;
                loop_start_d = loop_start_i;
                loop_end_d   = loop_end_i;
            end
        end else begin
            case (kind)
                EXEC: begin
                    ctrl_d  = payload;
                    advance = 1'b1;
                end
                NOP: advance = 1'b1;
                WAIT: begin
                    in_ready_d = 1'b1;
                    if (in_valid_i) begin
                        ctrl_d  = payload;
                        advance = 1'b1;
                    end
                end
                END: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    pc_d    = '0;
                end
            endcase

            // Loop branch wins over the implicit end at the last address.
            if (advance) begin
                if ((pc_q == loop_end_q) && (loop_start_q <= loop_end_q) &&
                    (loop_cnt_q != '0)) begin
                    pc_d       = loop_start_q;
                    loop_cnt_d = loop_cnt_q - LoopCntWidth'(1);
                end else if (pc_q == LastAddr) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    pc_d    = '0;
                end else begin
                    pc_d = pc_q + AddrWidth'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            loop_cnt_q   <= '0;
            loop_start_q <= '0;
            loop_end_q   <= '0;
            ctrl_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            loop_cnt_q   <= loop_cnt_d;
            loop_start_q <= loop_start_d;
            loop_end_q   <= loop_end_d;
            ctrl_q       <= ctrl_d;
            done_q       <= done_d;
        end
    end

    assign busy_o     = (state_q == ST_RUN);
    assign in_ready_o = in_ready_d;
    assign done_o     = done_q;
    assign ctrl_o     = ctrl_q;
    assign pc_o       = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_hv_encoder_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hv_encoder_ctrl                                                   |
// | Directed self-checking bench for hv_encoder_ctrl.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_hv_encoder_ctrl;

    localparam int NI = 32;
    localparam int CW = 34;
    localparam int LW = 8;
    localparam int IW = CW + 2;
    localparam int AW = 5;

    localparam logic [1:0] K_EXEC = 2'b00;
    localparam logic [1:0] K_NOP  = 2'b01;
    localparam logic [1:0] K_WAIT = 2'b10;
    localparam logic [1:0] K_END  = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_wr_en;
    logic [AW-1:0] prog_wr_addr;
    logic [IW-1:0] prog_wr_data;
    logic [AW-1:0] loop_start;
    logic [AW-1:0] loop_end;
    logic [LW-1:0] loop_count;
    logic          start;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] ctrl;
    logic [AW-1:0] pc;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    hv_encoder_ctrl #(
        .NumInst      (NI),
        .CtrlWidth    (CW),
        .LoopCntWidth (LW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .prog_wr_en_i   (prog_wr_en),
        .prog_wr_addr_i (prog_wr_addr),
        .prog_wr_data_i (prog_wr_data),
        .loop_start_i   (loop_start),
        .loop_end_i     (loop_end),
        .loop_count_i   (loop_count),
        .start_i        (start),
        .busy_o         (busy),
        .done_o         (done),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .ctrl_o         (ctrl),
        .pc_o           (pc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [1:0] k, input logic [CW-1:0] p);
        prog_wr_en   = 1'b1;
        prog_wr_addr = AW'(a);
        prog_wr_data = {k, p};
        step();
        prog_wr_en   = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        logic [CW-1:0] loop_seq [9];
        loop_seq = '{34'h0A, 34'h0B, 34'h0C, 34'h0B, 34'h0C,
                     34'h0B, 34'h0C, 34'h0B, 34'h0C};

        rst = 1'b1; prog_wr_en = 1'b0; prog_wr_addr = '0; prog_wr_data = '0;
        loop_start = '0; loop_end = '0; loop_count = '0; start = 1'b0; in_valid = 1'b0;
        step(); step();
        chk("rst_ctrl", 64'(ctrl), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_ready", 64'(in_ready), 64'h0);
        chk("rst_pc", 64'(pc), 64'h0);
        rst = 1'b0;

        // Linear program
        wr(0, K_EXEC, 34'h1); wr(1, K_EXEC, 34'h2); wr(2, K_END, 34'h3FF);
        go();
        chk("lin_busy0", 64'(busy), 64'h1);
        chk("lin_ctrl0", 64'(ctrl), 64'h0);
        step();
        chk("lin_w1", 64'(ctrl), 64'h1);
        chk("lin_busy1", 64'(busy), 64'h1);
        step();
        chk("lin_w2", 64'(ctrl), 64'h2);
        chk("lin_pc2", 64'(pc), 64'h2);
        step();
        chk("lin_end_ctrl", 64'(ctrl), 64'h0);
        chk("lin_done", 64'(done), 64'h1);
        chk("lin_idle", 64'(busy), 64'h0);
        step();
        chk("lin_done_pulse", 64'(done), 64'h0);

        // Loop body 1..2 repeated 3 extra times; RUN-time write/start injected
        wr(0, K_EXEC, 34'h0A); wr(1, K_EXEC, 34'h0B); wr(2, K_EXEC, 34'h0C); wr(3, K_END, 34'h0);
        loop_start = 5'd1; loop_end = 5'd2; loop_count = 8'd3;
        go();
        for (int i = 0; i < 9; i++) begin
            if (i == 3) begin
                start = 1'b1; prog_wr_en = 1'b1; prog_wr_addr = 5'd0;
                prog_wr_data = {K_EXEC, 34'h77};
            end
            step();
            start = 1'b0; prog_wr_en = 1'b0;
            chk($sformatf("loop_w%0d", i), 64'(ctrl), 64'(loop_seq[i]));
            chk($sformatf("loop_busy%0d", i), 64'(busy), 64'h1);
        end
        step();
        chk("loop_done", 64'(done), 64'h1);
        chk("loop_ctrl_end", 64'(ctrl), 64'h0);
        go();
        step();
        chk("rerun_w0", 64'(ctrl), 64'h0A);
        for (int i = 0; i < 9; i++) step();
        chk("rerun_done", 64'(done), 64'h1);
        step();

        // Zero loop count: body of two words once
        wr(0, K_EXEC, 34'h21); wr(1, K_EXEC, 34'h22); wr(2, K_END, 34'h0);
        loop_start = 5'd0; loop_end = 5'd1; loop_count = 8'd0;
        go();
        step(); chk("zl_w0", 64'(ctrl), 64'h21);
        step(); chk("zl_w1", 64'(ctrl), 64'h22);
        step(); chk("zl_done", 64'(done), 64'h1);
        chk("zl_ctrl", 64'(ctrl), 64'h0);
        step();

        // Handshake stall; loop_start > loop_end means linear
        wr(0, K_WAIT, 34'h5); wr(1, K_EXEC, 34'h6); wr(2, K_NOP, 34'h3FF); wr(3, K_END, 34'h0);
        loop_start = 5'd1; loop_end = 5'd0; loop_count = 8'd5;
        go();
        chk("hs_ready0", 64'(in_ready), 64'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("hs_pc%0d", i), 64'(pc), 64'h0);
            chk($sformatf("hs_ctrl%0d", i), 64'(ctrl), 64'h0);
            chk($sformatf("hs_ready%0d", i + 1), 64'(in_ready), 64'h1);
        end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("hs_xfer", 64'(ctrl), 64'h5);
        chk("hs_pc_adv", 64'(pc), 64'h1);
        chk("hs_ready_exec", 64'(in_ready), 64'h0);
        step(); chk("hs_next", 64'(ctrl), 64'h6);
        step(); chk("hs_nop", 64'(ctrl), 64'h0);
        chk("hs_nop_busy", 64'(busy), 64'h1);
        step(); chk("hs_done", 64'(done), 64'h1);
        step();

        // Implicit end: 32 EXECs, no END
        for (int i = 0; i < NI; i++) wr(i, K_EXEC, CW'(34'h100 + i));
        go();
        for (int i = 0; i < NI; i++) begin
            step();
            chk($sformatf("ie_w%0d", i), 64'(ctrl), 64'(34'h100 + i));
        end
        chk("ie_done", 64'(done), 64'h1);
        chk("ie_idle", 64'(busy), 64'h0);
        chk("ie_pc", 64'(pc), 64'h0);
        step();
        chk("ie_done_pulse", 64'(done), 64'h0);
        chk("ie_ctrl_idle", 64'(ctrl), 64'h0);

        // Abort mid-loop with reset
        wr(0, K_EXEC, 34'h0A); wr(1, K_EXEC, 34'h0B); wr(2, K_WAIT, 34'h0C); wr(3, K_END, 34'h0);
        loop_start = 5'd1; loop_end = 5'd2; loop_count = 8'd3;
        go();
        step(); step(); step();
        chk("ab_running", 64'(busy), 64'h1);
        chk("ab_ready", 64'(in_ready), 64'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ab_ctrl", 64'(ctrl), 64'h0);
        chk("ab_busy", 64'(busy), 64'h0);
        chk("ab_done", 64'(done), 64'h0);
        chk("ab_ready0", 64'(in_ready), 64'h0);
        chk("ab_pc", 64'(pc), 64'h0);
        step();
        chk("ab_done_after", 64'(done), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hv_encoder_ctrl.md
# hv_encoder_ctrl

Microcoded sequencer that drives the control ports of the HV encoder datapath (ALU muxes/ops, bundlers, register file, query HV register). Software loads a short program into a local instruction memory, then pulses start. The controller issues one registered control word per cycle and can repeat a loop body a programmed number of times. It can also stall on a valid/ready handshake with the item-memory data streamer.

## Interface
- NumInst, 32: instruction memory depth.
- CtrlWidth, 34: encoder control word width. Defaults match the encoder: 2+2+2+7+2+2+1+1+1+1+2+2+2+2+1+1+1+2.
- LoopCntWidth, 8: loop repeat counter width.
- InstWidth, CtrlWidth+2: derived, do not override.
- AddrWidth, $clog2(NumInst): derived, do not override.
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- prog_wr_en_i  in  1  instruction memory write strobe
- prog_wr_addr_i  in  AddrWidth  write address
- prog_wr_data_i  in  InstWidth  instruction {kind[1:0], payload[CtrlWidth-1:0]}
- loop_start_i  in  AddrWidth  first address of loop body
- loop_end_i  in  AddrWidth  last address of loop body, inclusive
- loop_count_i  in  LoopCntWidth  number of extra body repetitions
- start_i  in  1  start program at address 0
- busy_o  out  1  program running
- done_o  out  1  one-cycle pulse at program completion
- in_valid_i  in  1  streamer has item-memory data ready
- in_ready_o  out  1  controller consumes the streamer data this cycle
- ctrl_o  out  CtrlWidth  encoder control word, registered
- pc_o  out  AddrWidth  current program counter, for debug

## Operation
- States: IDLE and RUN.
- IDLE → RUN on start_i. Entering RUN loads pc=0 and loop_cnt=loop_count_i.
- start_i while in RUN is ignored.
- Loop inputs are sampled only at start. They must remain stable while busy_o is high.
- prog_wr_en_i writes memory only in IDLE. Writes in RUN are dropped.
- Memory contents are not affected by rst_i.
- In RUN, the instruction at pc is read combinationally. Behaviour by kind:
  - EXEC (2'b00): ctrl_o<=payload, then advance.
  - WAIT (2'b10): in_ready_o=1. If in_valid_i, ctrl_o<=payload and advance. Otherwise ctrl_o<=0 and pc holds.
  - NOP (2'b01): ctrl_o<=0, then advance.
  - END (2'b11): ctrl_o<=0, RUN→IDLE, done_o<=1.
- Advance rule:
  - If pc==loop_end_i and loop_cnt!=0: pc<=loop_start_i and loop_cnt--.
  - Otherwise, if pc==NumInst-1: treat as an implicit END. Go to IDLE, pulse done_o, pc<=0.
  - Otherwise pc<=pc+1.
- loop_count_i=0: the body runs once. loop_count_i=N: the body runs N+1 times.
- If loop_start_i>loop_end_i, no loop is taken and execution is linear.
- A WAIT at loop_end_i branches only on the cycle its handshake completes.
- in_ready_o is 0 outside RUN and for every non-WAIT instruction.
- ctrl_o is all-zero whenever no word is issued. This means idle, stall, NOP, and END. Zero means no write enables, no bundler valid/clear, no qhv write.

## Timing
- Reset values: ctrl_o=0, busy_o=0, done_o=0, in_ready_o=0, pc_o=0. State is IDLE and loop_cnt=0.
- start_i sampled at edge t sets busy_o=1 from t+1. Instruction 0 is fetched in cycle t+1. Its ctrl_o appears in cycle t+2.
- Issue latency is one cycle from fetch to ctrl_o. Throughput is one instruction per cycle with no bubbles on a loop branch.
- END fetched in cycle k gives busy_o=0 and done_o=1 in cycle k+1. done_o is high for exactly one cycle.
- Handshake: a transfer occurs in a cycle where in_valid_i && in_ready_o. The payload appears on ctrl_o in the next cycle.
- rst_i asserted mid-run takes effect on the next edge. All outputs return to reset values, with no done_o pulse.

## Structure
- Shared package hv_ctrl_pkg holds:
  - the inst_kind_e enum (EXEC/NOP/WAIT/END);
  - the packed ctrl_word_t struct with field order matching the encoder ports;
  - CtrlWidth.
- Sub-module: hv_ctrl_imem, a 1-write/1-read asynchronous-read register array of NumInst×InstWidth.
- FSM, program counter and loop counter live in the top module.

## Test plan
- Linear: program EXEC(0x1),EXEC(0x2),END; start → ctrl_o=0x1 then 0x2 on consecutive cycles. done_o is pulsed 1 cycle after END is fetched. busy_o is high for 3 cycles.
- Loop: body at addresses 1..2, loop_count_i=3, program EXEC(A),EXEC(B),EXEC(C),END → sequence A,B,C,B,C,B,C,B,C, then done_o.
- Handshake: WAIT(0x5) with in_valid_i low for 4 cycles → pc_o holds, ctrl_o=0, in_ready_o=1. Raise in_valid_i → 0x5 appears next cycle, then the next instruction.
- Implicit end: fill all 32 entries with EXEC and no END → 32 words issued, then IDLE with done_o pulsed and pc_o=0.
- Abort/guards: assert rst_i while looping → all outputs 0 next cycle and no done_o. A prog write and a start_i during RUN have no effect, confirmed by readback via a rerun.
- Zero loop count: loop_count_i=0 on a 2-word body → the body executes exactly once.
